// File: rtl/gnrl_regbank_arb_if.sv
// Write-request bundle for gnrl_regbank_arb: one valid/addr/data lane per requester plus the one-hot grant.
// req_lock exists only when GNRL_ARB_LOCK_EN is defined.
interface gnrl_regbank_arb_if #(
  parameter int N  = 4,
  parameter int DW = 32,
  parameter int AW = 3
);
  logic [N-1:0]    req_vld;
  logic [N*AW-1:0] req_addr;
  logic [N*DW-1:0] req_data;
  logic [N-1:0]    req_rdy;
`ifdef GNRL_ARB_LOCK_EN
  logic [N-1:0]    req_lock;

  modport master (output req_vld, req_addr, req_data, req_lock, input req_rdy);
  modport slave  (input req_vld, req_addr, req_data, req_lock, output req_rdy);
`else
  modport master (output req_vld, req_addr, req_data, input req_rdy);
  modport slave  (input req_vld, req_addr, req_data, output req_rdy);
`endif
endinterface

// File: rtl/gnrl_regbank_arb.sv
// Round-robin arbitrated register bank: N requesters write a 2^AW x DW bank, one grant per cycle.
// Optional macro GNRL_ARB_LOCK_EN adds req_lock and an IDLE/LOCKED ownership FSM.
module gnrl_regbank_arb #(
  parameter int N  = 4,
  parameter int DW = 32,
  parameter int AW = 3
) (
  input  logic                clk,
  input  logic                rst_n,
  gnrl_regbank_arb_if.slave   bus,
  input  logic [AW-1:0]       rd_addr,
  output logic [DW-1:0]       rd_data,
  output logic                gnt_vld,
  output logic [2:0]          gnt_idx,
  output logic [15:0]         wr_cnt
);

  logic [DW-1:0] bank_q [2**AW];
  logic [2:0]    rr_ptr_q, rr_ptr_d;
  logic [15:0]   wr_cnt_q;

  // Request lanes padded to 8 so the 3-bit winner index always selects in range.
  logic [7:0]    vld_pad;
  logic [AW-1:0] addr_a [8];
  logic [DW-1:0] data_a [8];

  logic [7:0]    elig;
  logic [3:0]    sum_c;
  logic [2:0]    win;
  logic          found;
  logic          gnt;
  logic [7:0]    gnt_oh;

`ifdef GNRL_ARB_LOCK_EN
  typedef enum logic {L_IDLE, L_LOCKED} lock_st_e;
  lock_st_e   lock_st_q;
  logic [2:0] owner_q;
  logic [7:0] lock_pad;
  logic       lock_exit;
`endif

  for (genvar g = 0; g < 8; g++) begin : g_pad
    if (g < N) begin : g_req
      assign vld_pad[g] = bus.req_vld[g];
      assign addr_a[g]  = bus.req_addr[g*AW +: AW];
      assign data_a[g]  = bus.req_data[g*DW +: DW];
`ifdef GNRL_ARB_LOCK_EN
      assign lock_pad[g] = bus.req_lock[g];
`endif
    end else begin : g_nul
      assign vld_pad[g] = 1'b0;
      assign addr_a[g]  = '0;
      assign data_a[g]  = '0;
`ifdef GNRL_ARB_LOCK_EN
      assign lock_pad[g] = 1'b0;
`endif
    end
  end

  function automatic logic [2:0] inc_mod(input logic [2:0] x);
    return (x == 3'(N-1)) ? 3'd0 : x + 3'd1;
  endfunction

  always_comb begin
    elig = vld_pad;
`ifdef GNRL_ARB_LOCK_EN
    if (lock_st_q == L_LOCKED) elig = vld_pad & (8'b1 << owner_q);
`endif
  end

  // First eligible requester scanning upward from rr_ptr, wrapping at N.
  always_comb begin
    found = 1'b0;
    win   = '0;
    sum_c = '0;
    for (int unsigned off = 0; off < N; off++) begin
      sum_c = {1'b0, rr_ptr_q} + 4'(off);
      if (sum_c >= 4'(N)) sum_c = sum_c - 4'(N);
      if (!found && elig[sum_c[2:0]]) begin
        found = 1'b1;
        win   = sum_c[2:0];
      end
    end
  end

  assign gnt         = found & rst_n;
  assign gnt_oh      = gnt ? (8'b1 << win) : '0;
  assign bus.req_rdy = gnt_oh[N-1:0];
  assign gnt_vld     = gnt;
  assign gnt_idx     = gnt ? win : 3'd0;
  assign rd_data     = bank_q[rd_addr];
  assign wr_cnt      = wr_cnt_q;

`ifdef GNRL_ARB_LOCK_EN
  // While locked a grant can only go to the owner, so gnt alone identifies an owner write.
  assign lock_exit = !vld_pad[owner_q] || (gnt && !lock_pad[owner_q]);
`endif

  always_comb begin
    rr_ptr_d = rr_ptr_q;
`ifdef GNRL_ARB_LOCK_EN
    if (lock_st_q == L_LOCKED) begin
      if (lock_exit) rr_ptr_d = inc_mod(owner_q);
    end else if (gnt) begin
      rr_ptr_d = inc_mod(win);
    end
`else
    if (gnt) rr_ptr_d = inc_mod(win);
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bank_q   <= '{default: '0};
      rr_ptr_q <= '0;
      wr_cnt_q <= '0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
      if (gnt) begin
        bank_q[addr_a[win]] <= data_a[win];
        if (wr_cnt_q != 16'hFFFF) wr_cnt_q <= wr_cnt_q + 16'd1;
      end
    end
  end

`ifdef GNRL_ARB_LOCK_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lock_st_q <= L_IDLE;
      owner_q   <= '0;
    end else begin
      case (lock_st_q)
        L_IDLE: begin
          if (gnt && lock_pad[win]) begin
            lock_st_q <= L_LOCKED;
            owner_q   <= win;
          end
        end
        L_LOCKED: begin
          if (lock_exit) lock_st_q <= L_IDLE;
        end
        default: lock_st_q <= L_IDLE;
      endcase
    end
  end
`endif

endmodule

// File: tb/tb_gnrl_regbank_arb.sv
// Self-checking bench for gnrl_regbank_arb: directed vector table, corner sequences, random vs reference model.
module tb_gnrl_regbank_arb;
  localparam int N  = 4;
  localparam int DW = 32;
  localparam int AW = 3;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  gnrl_regbank_arb_if #(.N(N), .DW(DW), .AW(AW)) bus_if ();
  logic [AW-1:0] rd_addr;
  logic [DW-1:0] rd_data;
  logic          gnt_vld;
  logic [2:0]    gnt_idx;
  logic [15:0]   wr_cnt;

  gnrl_regbank_arb #(.N(N), .DW(DW), .AW(AW)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .bus     (bus_if),
    .rd_addr (rd_addr),
    .rd_data (rd_data),
    .gnt_vld (gnt_vld),
    .gnt_idx (gnt_idx),
    .wr_cnt  (wr_cnt)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Reference model: bank contents, pointer, counter, lock ownership.
  logic [DW-1:0] m_bank [2**AW];
  int m_ptr, m_cnt, m_owner;
  bit m_locked;

  task automatic m_reset();
    for (int i = 0; i < 2**AW; i++) m_bank[i] = '0;
    m_ptr = 0; m_cnt = 0; m_locked = 0; m_owner = 0;
  endtask

  function automatic int m_winner(input logic [N-1:0] v);
    if (m_locked) return v[m_owner] ? m_owner : -1;
    for (int off = 0; off < N; off++) begin
      int k;
      k = (m_ptr + off) % N;
      if (v[k]) return k;
    end
    return -1;
  endfunction

  task automatic m_step(input int w);
    logic [AW-1:0] a;
    if (w >= 0) begin
      a = bus_if.req_addr[w*AW +: AW];
      m_bank[a] = bus_if.req_data[w*DW +: DW];
      if (m_cnt < 65535) m_cnt++;
    end
`ifdef GNRL_ARB_LOCK_EN
    if (m_locked) begin
      if (!bus_if.req_vld[m_owner] || (w == m_owner && !bus_if.req_lock[m_owner])) begin
        m_locked = 0;
        m_ptr = (m_owner + 1) % N;
      end
    end else if (w >= 0) begin
      m_ptr = (w + 1) % N;
      if (bus_if.req_lock[w]) begin m_locked = 1; m_owner = w; end
    end
`else
    if (w >= 0) m_ptr = (w + 1) % N;
`endif
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    bus_if.req_vld = '1;
    #1;
    check("reset rdy", bus_if.req_rdy, '0);
    check("reset gnt_vld", gnt_vld, 1'b0);
    check("reset wr_cnt", wr_cnt, 16'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    bus_if.req_vld = '0;
    m_reset();
  endtask

  typedef struct {
    logic [N-1:0]    vld;
    logic [N*AW-1:0] addr;
    logic [N*DW-1:0] data;
    logic [AW-1:0]   ra;
    logic [N-1:0]    rdy;
    logic [2:0]      idx;
    logic [DW-1:0]   rd;
    logic [15:0]     cnt;
  } vec_t;

  localparam logic [N*AW-1:0] A_SEQ  = {3'd3, 3'd2, 3'd1, 3'd0};
  localparam logic [N*AW-1:0] A_R2_5 = {3'd0, 3'd5, 3'd0, 3'd0};
  localparam logic [N*AW-1:0] A_ZERO = '0;
  localparam logic [N*AW-1:0] A_SEVN = {3'd7, 3'd7, 3'd7, 3'd7};
  localparam logic [N*DW-1:0] D_SEQ  = {32'h103, 32'h102, 32'h101, 32'h100};
  localparam logic [N*DW-1:0] D_BEEF = {32'h0, 32'hDEADBEEF, 32'h0, 32'h0};
  localparam logic [N*DW-1:0] D_13   = {32'hBBBB0003, 32'h0, 32'hAAAA0001, 32'h0};

  vec_t tbl [10];

  initial begin
    tbl[0] = '{4'b1111, A_SEQ,  D_SEQ,  3'd0, 4'b0001, 3'd0, 32'h0,        16'd0};
    tbl[1] = '{4'b1111, A_SEQ,  D_SEQ,  3'd0, 4'b0010, 3'd1, 32'h100,      16'd1};
    tbl[2] = '{4'b1111, A_SEQ,  D_SEQ,  3'd1, 4'b0100, 3'd2, 32'h101,      16'd2};
    tbl[3] = '{4'b1111, A_SEQ,  D_SEQ,  3'd2, 4'b1000, 3'd3, 32'h102,      16'd3};
    tbl[4] = '{4'b1111, A_SEQ,  D_SEQ,  3'd3, 4'b0001, 3'd0, 32'h103,      16'd4};
    tbl[5] = '{4'b0100, A_R2_5, D_BEEF, 3'd5, 4'b0100, 3'd2, 32'h0,        16'd5};
    tbl[6] = '{4'b0000, A_R2_5, D_BEEF, 3'd5, 4'b0000, 3'd0, 32'hDEADBEEF, 16'd6};
    tbl[7] = '{4'b0010, A_ZERO, D_13,   3'd0, 4'b0010, 3'd1, 32'h100,      16'd6};
    tbl[8] = '{4'b1000, A_ZERO, D_13,   3'd0, 4'b1000, 3'd3, 32'hAAAA0001, 16'd7};
    tbl[9] = '{4'b1111, A_SEVN, D_SEQ,  3'd0, 4'b0001, 3'd0, 32'hBBBB0003, 16'd8};

    bus_if.req_vld  = '0;
    bus_if.req_addr = '0;
    bus_if.req_data = '0;
`ifdef GNRL_ARB_LOCK_EN
    bus_if.req_lock = '0;
`endif
    rd_addr = '0;
    do_reset();

    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      bus_if.req_vld  = tbl[i].vld;
      bus_if.req_addr = tbl[i].addr;
      bus_if.req_data = tbl[i].data;
      rd_addr         = tbl[i].ra;
      #1;
      check($sformatf("vec%0d rdy", i), bus_if.req_rdy, tbl[i].rdy);
      check($sformatf("vec%0d gnt_idx", i), gnt_idx, tbl[i].idx);
      check($sformatf("vec%0d gnt_vld", i), gnt_vld, tbl[i].rdy != '0);
      check($sformatf("vec%0d rd_data", i), rd_data, tbl[i].rd);
      check($sformatf("vec%0d wr_cnt", i), wr_cnt, tbl[i].cnt);
    end
    @(negedge clk);
    bus_if.req_vld = '0;
    rd_addr = 3'd7;
    #1;
    check("table final wr_cnt", wr_cnt, 16'd9);
    check("table final bank7", rd_data, 32'h100);

    // Reset pulsed mid-stream after three writes.
    bus_if.req_addr = A_SEQ;
    bus_if.req_data = D_SEQ;
    bus_if.req_vld  = '1;
    repeat (3) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst rdy", bus_if.req_rdy, '0);
    check("midrst gnt_vld", gnt_vld, 1'b0);
    check("midrst wr_cnt", wr_cnt, 16'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    bus_if.req_vld = '0;
    #1;
    for (int a = 0; a < 2**AW; a++) begin
      rd_addr = AW'(a);
      #1;
      check($sformatf("post-rst bank%0d", a), rd_data, 32'h0);
    end
    bus_if.req_vld = 4'b1100;
    #1;
    check("post-rst rdy", bus_if.req_rdy, 4'b0100);
    check("post-rst gnt_idx", gnt_idx, 3'd2);

    // Counter saturation from a forced preset.
    @(negedge clk);
    bus_if.req_vld = '0;
    force dut.wr_cnt_q = 16'hFFFE;
    #1;
    release dut.wr_cnt_q;
    #1;
    check("sat preset", wr_cnt, 16'hFFFE);
    bus_if.req_vld = 4'b0001;
    repeat (3) @(negedge clk);
    bus_if.req_vld = '0;
    #1;
    check("sat after 3", wr_cnt, 16'hFFFF);
    @(negedge clk);
    #1;
    check("sat held", wr_cnt, 16'hFFFF);

`ifdef GNRL_ARB_LOCK_EN
    begin
      int exp_l [4];
      exp_l = '{0, 0, 0, 1};
      @(negedge clk);
      do_reset();
      bus_if.req_addr = A_SEQ;
      bus_if.req_data = D_SEQ;
      for (int i = 0; i < 4; i++) begin
        if (i != 0) @(negedge clk);
        bus_if.req_vld  = '1;
        bus_if.req_lock = (i < 2) ? 4'b0001 : 4'b0000;
        #1;
        check($sformatf("lock seq%0d gnt_idx", i), gnt_idx, 3'(exp_l[i]));
      end
      @(negedge clk);
      bus_if.req_vld  = '0;
      bus_if.req_lock = '0;
    end
`endif

    // Randomized traffic against the reference model.
    @(negedge clk);
    do_reset();
    for (int c = 0; c < 400; c++) begin
      int w;
      logic [N-1:0] ev;
      @(negedge clk);
      bus_if.req_vld  = ($urandom_range(0, 7) == 0) ? '0 : N'($urandom);
      bus_if.req_addr = (N*AW)'({$urandom, $urandom});
      bus_if.req_data = {$urandom, $urandom, $urandom, $urandom};
      rd_addr         = AW'($urandom);
`ifdef GNRL_ARB_LOCK_EN
      bus_if.req_lock = N'($urandom) & N'($urandom);
`endif
      #1;
      w  = m_winner(bus_if.req_vld);
      ev = (w >= 0) ? N'(1 << w) : '0;
      check($sformatf("rnd%0d rdy", c), bus_if.req_rdy, ev);
      check($sformatf("rnd%0d gnt_idx", c), gnt_idx, (w >= 0) ? 3'(w) : 3'd0);
      check($sformatf("rnd%0d gnt_vld", c), gnt_vld, w >= 0);
      check($sformatf("rnd%0d rd_data", c), rd_data, m_bank[rd_addr]);
      check($sformatf("rnd%0d wr_cnt", c), wr_cnt, 16'(m_cnt));
      @(posedge clk);
      m_step(w);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
